// File: rtl/enter_parking_lot.sv
// Parking-lot entry allocator: 4-phase request/grant for the lowest free slot plus a parallel exit path.
// Optional grant-hold timeout is compiled in with `define PARK_TIMEOUT_EN.
module enter_parking_lot #(
  parameter int ID_W           = 3,
  parameter int NUM_SLOTS      = 2**ID_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 car_arrive,
  output logic                 park_grant,
  output logic [ID_W-1:0]      park_number,
  output logic                 lot_full,
  input  logic                 car_exit,
  input  logic [ID_W-1:0]      exit_number,
  output logic                 exit_error,
  output logic [NUM_SLOTS-1:0] park_location,
  output logic [ID_W:0]        free_count
);
  localparam int FW = ID_W + 1;
  localparam logic [1:0] S_IDLE   = 2'd0,
                         S_SEARCH = 2'd1,
                         S_GRANT  = 2'd2,
                         S_HOLD   = 2'd3;

  logic [1:0]           state, state_next;
  logic [ID_W-1:0]      candidate, first_free;
  logic                 commit, exit_hit, exit_miss, rel, rel_hit;
  logic [NUM_SLOTS-1:0] set_mask, clr_mask, loc_next;
  logic [FW-1:0]        free_next;

  // Lowest-index free slot wins
  always_comb begin
    first_free = '0;
    for (int i = NUM_SLOTS-1; i >= 0; i--)
      if (!park_location[i]) first_free = ID_W'(i);
  end

  assign commit    = (state == S_GRANT);
  assign exit_hit  = car_exit &&  park_location[exit_number];
  assign exit_miss = car_exit && !park_location[exit_number];

`ifdef PARK_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          released;

  assign rel = (state == S_HOLD) && car_arrive && !released &&
               (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt   <= '0;
      released <= 1'b0;
    end else if (state != S_HOLD) begin
      to_cnt   <= '0;
      released <= 1'b0;
    end else if (rel) begin
      released <= 1'b1;
    end else if (!released) begin
      to_cnt   <= to_cnt + 1'b1;
    end
  end
`else
  assign rel = 1'b0;
`endif

  // A release racing a valid exit of the same slot must only free it once
  assign rel_hit = rel && park_location[candidate] &&
                   !(exit_hit && (exit_number == candidate));

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (commit)   set_mask[candidate]   = 1'b1;
    if (exit_hit) clr_mask[exit_number] = 1'b1;
    if (rel_hit)  clr_mask[candidate]   = 1'b1;
  end

  assign loc_next  = (park_location | set_mask) & ~clr_mask;
  assign free_next = free_count - FW'(commit) + FW'(exit_hit) + FW'(rel_hit);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (car_arrive && (free_count != '0)) state_next = S_SEARCH;
      S_SEARCH: state_next = S_GRANT;
      S_GRANT:  state_next = S_HOLD;
      S_HOLD:   if (!car_arrive) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      candidate     <= '0;
      park_grant    <= 1'b0;
      park_location <= '0;
      free_count    <= FW'(NUM_SLOTS);
      lot_full      <= 1'b0;
      exit_error    <= 1'b0;
    end else begin
      state         <= state_next;
      if (state == S_SEARCH) candidate <= first_free;
      park_grant    <= (state == S_SEARCH);
      park_location <= loc_next;
      free_count    <= free_next;
      lot_full      <= (free_next == '0);
      exit_error    <= exit_miss;
    end
  end

  assign park_number = candidate;

endmodule

// File: doc/enter_parking_lot.md
Name: enter_parking_lot

Overview:
Entry-side counterpart of the lot's exit decoding. It tracks occupancy of the 8 parking slots and allocates the lowest-numbered free slot to an arriving car using a 4-phase request/grant handshake. It outputs the binary park number and frees slots on exit requests. It sits between the entry gate sensor and the display/exit logic. Its occupancy bitmap uses the same one-hot slot ordering as the exit path: bit i = slot i.

Parameters:
NUM_SLOTS, 8, number of slots; fixed at 2**ID_W.
ID_W, 3, width of park/exit slot numbers.
TIMEOUT_CYCLES, 16, grant-hold limit; used only when PARK_TIMEOUT_EN is defined.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
car_arrive  input  1  entry request, level; held until grant seen, then dropped.
park_grant  output  1  one-cycle pulse: park_number is valid and the slot is committed.
park_number  output  ID_W  allocated slot; held stable from grant until the next grant.
lot_full  output  1  high while free_count == 0.
car_exit  input  1  one-cycle exit strobe.
exit_number  input  ID_W  slot being vacated; qualified by car_exit.
exit_error  output  1  one-cycle pulse: car_exit targeted an unoccupied slot.
park_location  output  NUM_SLOTS  occupancy bitmap, registered.
free_count  output  ID_W+1  number of free slots, 0..8.

Behaviour:
- Clock and reset: one clock domain. rst_n low asynchronously clears all state.
  - Reset values: park_grant=0, park_number=0, park_location=0, free_count=8, lot_full=0, exit_error=0, FSM=IDLE.
  - Reset mid-handshake aborts the transaction. No slot stays allocated.
- FSM states:
  - IDLE: if car_arrive=1 and free_count>0, go to SEARCH. If car_arrive=1 and lot full, stay in IDLE with the request pending; it proceeds once a slot frees.
  - SEARCH: priority-encode the lowest index i with park_location[i]=0, using the bitmap as registered this cycle. Latch i into an internal candidate register. Go to GRANT.
  - GRANT: drive park_number=candidate and park_grant=1 for exactly this cycle. Set park_location[candidate] and decrement free_count at this edge. Go to HOLD.
  - HOLD: wait for car_arrive=0, then go to IDLE. A new request needs car_arrive to drop first (4-phase handshake).
- Latency: car_arrive sampled high in IDLE at edge N gives park_grant high during cycle N+2.
- Exit path: runs in parallel with the FSM, in any state.
  - car_exit=1 with park_location[exit_number]=1: clear the bit and increment free_count at the next edge.
  - car_exit=1 with the bit already 0: exit_error pulses for 1 cycle (registered, next cycle). Bitmap and count are unchanged.
- Simultaneous grant commit and valid exit in the same cycle: both apply. Net free_count is unchanged. The two slots always differ, because the candidate is free, so an exit on it is an error.
- Exit clearing a slot lower than the candidate while in SEARCH/GRANT: the candidate is not re-evaluated; the grant uses the latched value.
- lot_full is a registered decode of free_count == 0. It updates the same edge free_count changes.
- Invariant: free_count == NUM_SLOTS - popcount(park_location) at all times.

Optional Feature:
PARK_TIMEOUT_EN.
- Defined: a counter starts in HOLD. If car_arrive is still high after TIMEOUT_CYCLES cycles in HOLD, the allocated slot is released: its bit is cleared and free_count is incremented. The FSM then returns to IDLE only after car_arrive drops, and no new grant is issued for that request.
- Undefined: HOLD waits indefinitely. No counter logic is present.

Test Plan:
- Reset, then car_arrive=1 -> park_grant pulse 2 cycles later; park_number=0; park_location=8'b00000001; free_count=7.
- 8 sequential handshakes -> park_number 0..7 in order; park_location=8'hFF; free_count=0; lot_full=1. A 9th car_arrive gets no grant.
- Full lot, 9th request pending, car_exit with exit_number=3 -> bit 3 clears, lot_full drops, then the pending request is granted with park_number=3 and park_location returns to 8'hFF.
- park_location=8'b00000101, car_exit with exit_number=1 -> exit_error pulses 1 cycle; park_location and free_count are unchanged.
- Grant commit for slot 1 in the same cycle as car_exit for slot 0, starting from 8'b00000001 -> next park_location=8'b00000010; free_count stays 7.
- rst_n asserted while in GRANT -> all outputs reach reset values immediately and park_location=0. With PARK_TIMEOUT_EN defined, holding car_arrive for 16 cycles in HOLD releases the slot and restores free_count.
